// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller:
// stall encodings, reset/stop levels, ERET code and FSM state encodings.
package pipe_ctrl_pkg;

    localparam logic RstEnable = 1'b1;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    localparam logic [31:0] ExcEret = 32'h0000_000e;

    // Stall vector bit order: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallIf   = 6'b000011;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;
    localparam logic [5:0] StallAll  = 6'b111111;

    typedef enum logic [1:0] {
        PcIdle    = 2'd0,
        PcWaitBus = 2'd1,
        PcFlush   = 2'd2
    } pc_state_t;

    // Highest-priority stage request wins: later stages stall everything upstream.
    function automatic logic [5:0] stall_from_reqs(input logic req_if, input logic req_id,
                                                   input logic req_ex, input logic req_mem);
        logic [5:0] s;
        s = StallNone;
        if (req_mem)     s = StallMem;
        else if (req_ex) s = StallEx;
        else if (req_id) s = StallId;
        else if (req_if) s = StallIf;
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating at WDT_LIMIT)
// and raises a sticky timeout flag once the count reaches WDT_LIMIT.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDT_LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(WDT_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(WDT_LIMIT);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (stalled) begin
            cnt_d = (cnt_q == Limit) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (stalled && (cnt_d == Limit)) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: priority stall resolution plus exception/ERET
// redirect sequencing. Optional stall watchdog under PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned WDT_LIMIT  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        ibus_busy_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        wdt_timeout_o,
    output pc_state_t   state_dbg
);

    pc_state_t   state_q, state_d;
    logic [31:0] target_q, target_d;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= PcIdle;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Exceptions arriving outside IDLE are dropped: the first one owns the redirect.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        stall    = StallNone;
        case (state_q)
            PcIdle: begin
                if (excepttype_i != 32'h0) begin
                    stall    = StallAll;
                    target_d = (excepttype_i == ExcEret) ? cp0_epc_i : EXC_VECTOR;
                    state_d  = ibus_busy_i ? PcWaitBus : PcFlush;
                end else begin
                    stall = stall_from_reqs(stallreq_from_if, stallreq_from_id,
                                            stallreq_from_ex, stallreq_from_mem);
                end
            end
            PcWaitBus: begin
                stall = StallAll;
                if (!ibus_busy_i) begin
                    state_d = PcFlush;
                end
            end
            PcFlush: begin
                stall   = StallNone;
                state_d = PcIdle;
            end
            default: begin
                state_d = PcIdle;
            end
        endcase
    end

    // Decoded only from registered state so flush/new_pc cannot glitch on input changes.
    assign flush     = (state_q == PcFlush);
    assign new_pc    = flush ? target_q : 32'h0;
    assign state_dbg = state_q;

`ifdef PIPE_CTRL_WATCHDOG_EN
    stall_watchdog #(
        .WDT_LIMIT (WDT_LIMIT)
    ) u_stall_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stalled (stall != StallNone),
        .timeout (wdt_timeout_o)
    );
`else
    assign wdt_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall priority, exception and
// ERET redirects, bus wait, first-exception-wins, reset abort and watchdog.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        stallreq_from_if;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic        ibus_busy_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdt_timeout_o;
    pc_state_t   state_dbg;

    int tests_run;
    int tests_failed;
    int flush_cnt;
    logic [31:0] pc_at_flush;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDT_LIMIT  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .ibus_busy_i       (ibus_busy_i),
        .excepttype_i      (excepttype_i),
        .cp0_epc_i         (cp0_epc_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .wdt_timeout_o     (wdt_timeout_o),
        .state_dbg         (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_from_if  = 1'b0;
        stallreq_from_id  = 1'b0;
        stallreq_from_ex  = 1'b0;
        stallreq_from_mem = 1'b0;
        ibus_busy_i       = 1'b0;
        excepttype_i      = 32'h0;
        cp0_epc_i         = 32'h0;
    endtask

    task automatic set_reqs(input logic [3:0] r);
        {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Stall priority table: {mem, ex, id, if} -> expected stall vector.
    logic [3:0] vec_req [8];
    logic [5:0] vec_exp [8];

    initial begin
        vec_req[0] = 4'b0000; vec_exp[0] = 6'b000000;
        vec_req[1] = 4'b0001; vec_exp[1] = 6'b000011;
        vec_req[2] = 4'b0010; vec_exp[2] = 6'b000111;
        vec_req[3] = 4'b0110; vec_exp[3] = 6'b001111;
        vec_req[4] = 4'b0010; vec_exp[4] = 6'b000111;
        vec_req[5] = 4'b1111; vec_exp[5] = 6'b011111;
        vec_req[6] = 4'b0101; vec_exp[6] = 6'b001111;
        vec_req[7] = 4'b0011; vec_exp[7] = 6'b000111;
    end

    // ---------------- main sequence ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        clear_inputs();
        do_reset();

        check("reset_stall", {26'h0, stall}, 32'h0);
        check("reset_flush", {31'h0, flush}, 32'h0);
        check("reset_new_pc", new_pc, 32'h0);
        check("reset_wdt", {31'h0, wdt_timeout_o}, 32'h0);
        check("reset_state", {30'h0, state_dbg}, {30'h0, PcIdle});

        // Stall priority, zero-cycle latency.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_reqs(vec_req[i]);
            #1;
            check($sformatf("prio_%0d", i), {26'h0, stall}, {26'h0, vec_exp[i]});
            check($sformatf("prio_noflush_%0d", i), {31'h0, flush}, 32'h0);
        end
        @(negedge clk);
        clear_inputs();

        // Exception, bus idle, with a stall request also present.
        @(negedge clk);
        excepttype_i = 32'h0000_0008;
        stallreq_from_mem = 1'b1;
        #1;
        check("exc_stall_n", {26'h0, stall}, 32'h3f);
        check("exc_flush_n", {31'h0, flush}, 32'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("exc_flush_n1", {31'h0, flush}, 32'h1);
        check("exc_pc_n1", new_pc, 32'h0000_0020);
        check("exc_stall_n1", {26'h0, stall}, 32'h0);
        step();
        check("exc_flush_n2", {31'h0, flush}, 32'h0);
        check("exc_pc_n2", new_pc, 32'h0);

        // ERET with bus busy for 3 cycles.
        @(negedge clk);
        excepttype_i = ExcEret;
        cp0_epc_i    = 32'h0000_1234;
        ibus_busy_i  = 1'b1;
        #1;
        check("eret_stall_0", {26'h0, stall}, 32'h3f);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            excepttype_i = 32'h0;
            cp0_epc_i    = 32'h0;
            #1;
            check($sformatf("eret_stall_%0d", i), {26'h0, stall}, 32'h3f);
            check($sformatf("eret_noflush_%0d", i), {31'h0, flush}, 32'h0);
        end
        @(negedge clk);
        ibus_busy_i = 1'b0;
        #1;
        check("eret_stall_release", {26'h0, stall}, 32'h3f);
        flush_cnt = 0;
        pc_at_flush = 32'h0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (flush) begin
                flush_cnt++;
                pc_at_flush = new_pc;
            end
            if (i == 0) check("eret_flush_timing", {31'h0, flush}, 32'h1);
        end
        check("eret_flush_count", flush_cnt, 32'd1);
        check("eret_new_pc", pc_at_flush, 32'h0000_1234);

        // Second exception during WAIT_BUS is ignored.
        @(negedge clk);
        excepttype_i = 32'h0000_0008;
        ibus_busy_i  = 1'b1;
        @(negedge clk);
        excepttype_i = ExcEret;
        cp0_epc_i    = 32'h0000_5555;
        #1;
        check("second_exc_state", {30'h0, state_dbg}, {30'h0, PcWaitBus});
        @(negedge clk);
        clear_inputs();
        flush_cnt = 0;
        pc_at_flush = 32'h0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (flush) begin
                flush_cnt++;
                pc_at_flush = new_pc;
            end
        end
        check("second_exc_flush_count", flush_cnt, 32'd1);
        check("second_exc_new_pc", pc_at_flush, 32'h0000_0020);

        // Reset while in WAIT_BUS aborts the redirect.
        @(negedge clk);
        excepttype_i = 32'h0000_0004;
        ibus_busy_i  = 1'b1;
        @(negedge clk);
        excepttype_i = 32'h0;
        rst = 1'b1;
        #1;
        check("rst_pre_state", {30'h0, state_dbg}, {30'h0, PcWaitBus});
        @(negedge clk);
        rst = 1'b0;
        ibus_busy_i = 1'b0;
        #1;
        check("rst_abort_state", {30'h0, state_dbg}, {30'h0, PcIdle});
        check("rst_abort_stall", {26'h0, stall}, 32'h0);
        check("rst_abort_new_pc", new_pc, 32'h0);
        flush_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (flush) flush_cnt++;
            step();
        end
        check("rst_abort_no_flush", flush_cnt, 32'd0);
        check("rst_abort_wdt", {31'h0, wdt_timeout_o}, 32'h0);

        // Watchdog: WDT_LIMIT=4, mem request held.
        do_reset();
        @(negedge clk);
        stallreq_from_mem = 1'b1;
        #1;
        for (int i = 1; i <= 5; i++) begin
            step();
`ifdef PIPE_CTRL_WATCHDOG_EN
            check($sformatf("wdt_hold_%0d", i), {31'h0, wdt_timeout_o}, (i >= 4) ? 32'h1 : 32'h0);
`else
            check($sformatf("wdt_hold_%0d", i), {31'h0, wdt_timeout_o}, 32'h0);
`endif
        end
        @(negedge clk);
        stallreq_from_mem = 1'b0;
        step();
        step();
`ifdef PIPE_CTRL_WATCHDOG_EN
        check("wdt_sticky", {31'h0, wdt_timeout_o}, 32'h1);
`else
        check("wdt_sticky", {31'h0, wdt_timeout_o}, 32'h0);
`endif
        do_reset();
        check("wdt_reset_clear", {31'h0, wdt_timeout_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "time limit");
    end

endmodule
